// File: rtl/riscv_prefetch_req_ctrl.sv
// riscv_prefetch_req_ctrl
// Instruction-side fetch request generator. Issues sequential word-aligned
// requests on a req/gnt/rvalid memory port, tracks up to MAX_OUTSTANDING
// granted-but-unanswered requests in an in-order address queue, and pushes
// each response with its address into the fetch FIFO. Branches flush the
// FIFO, drop the responses already in flight and restart at the target.
//
// Optional build macro: RISCV_PREFETCH_HWLP_EN adds hardware-loop jumps,
// which redirect like a branch without flushing the FIFO and tag the first
// forwarded word with fifo_replace2_o / fifo_is_hwlp_o.
//
// Handshake: a request is offered while instr_req_o is high and is accepted
// in the cycle instr_gnt_i is high; until then instr_req_o and instr_addr_o
// stay constant. Responses return in request order, one per instr_rvalid_i
// cycle. fifo_valid_o is a single-cycle push the FIFO always accepts
// (fifo_ready_i guarantees room before each new request is issued).
module riscv_prefetch_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
`ifdef RISCV_PREFETCH_HWLP_EN
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i,
  output logic        fifo_replace2_o,
  output logic        fifo_is_hwlp_o,
`endif
  output logic        busy_o
);

  localparam int CW = 3;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            first_q, first_d;
  logic            first_bit_q, first_bit_d;
  // Redirect that arrived while a request was held un-granted; applied
  // once that request is granted so instr_addr_o never changes mid-request.
  logic            pend_q, pend_d;
  logic [31:0]     pend_addr_q, pend_addr_d;
  logic [31:0]     aq_q [MAX_OUTSTANDING];

  logic            gnt_fire;
  logic            rsp_fire;
  logic            drop_now;
  logic            fwd;
  logic            held;
  logic            issue_ok;
  logic            redir;
  logic [31:0]     redir_addr;
  logic [31:0]     redir_word;
  logic [31:0]     pop_addr;

`ifdef RISCV_PREFETCH_HWLP_EN
  logic            hwlp_jmp;
  logic            hwlp_q, hwlp_d;

  // Branch has priority over a hardware-loop jump in the same cycle.
  always_comb begin
    hwlp_jmp   = hwlp_jump_i & ~branch_i;
    redir      = branch_i | hwlp_jump_i;
    redir_addr = branch_i ? branch_addr_i : hwlp_target_i;
  end
`else
  // Only branches redirect fetch in this build.
  always_comb begin
    redir      = branch_i;
    redir_addr = branch_addr_i;
  end
`endif

  // Transfer qualifiers shared by the FSM, counters and FIFO port.
  always_comb begin
    gnt_fire   = (state_q == REQ) & instr_gnt_i;
    rsp_fire   = instr_rvalid_i & (cnt_q != '0);
    held       = (state_q == REQ) & ~instr_gnt_i;
    drop_now   = rsp_fire & ((drop_q != '0) | redir);
    fwd        = rsp_fire & ~drop_now;
    redir_word = {redir_addr[31:2], 2'b00};
    pop_addr   = aq_q[rd_ptr_q];
  end

  // Outstanding count after this cycle's grant and response.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({gnt_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    issue_ok = fetch_en_i & fifo_ready_i & (cnt_d < MAX_CNT) & ~redir;
  end

  // FSM next state: a held request is never withdrawn.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = issue_ok ? REQ : IDLE;
      REQ:  state_d = instr_gnt_i ? (issue_ok ? REQ : IDLE) : REQ;
      default: state_d = IDLE;
    endcase
  end

  // Fetch address, queue pointers, drop count and post-branch marking.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_d       = drop_q;
    first_d      = first_q;
    first_bit_d  = first_bit_q;

    if (gnt_fire) begin
      fetch_addr_d = pend_q ? pend_addr_q : fetch_addr_q + 32'd4;
      pend_d       = 1'b0;
      wr_ptr_d     = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rsp_fire) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (drop_q != '0) drop_d = drop_q - 1'b1;
    end
    if (fwd) first_d = 1'b0;

    if (redir) begin
      if (held) begin
        pend_d      = 1'b1;
        pend_addr_d = redir_word;
      end else begin
        fetch_addr_d = redir_word;
        pend_d       = 1'b0;
      end
      // The held request's response is stale too; it is the last one due.
      drop_d      = cnt_d + {{(CW-1){1'b0}}, held};
      first_d     = 1'b1;
      first_bit_d = redir_addr[1];
    end
  end

`ifdef RISCV_PREFETCH_HWLP_EN
  // Hardware-loop tag follows the same lifetime as the first-word flag.
  always_comb begin
    hwlp_d = hwlp_q;
    if (fwd) hwlp_d = 1'b0;
    if (redir) hwlp_d = hwlp_jmp;
  end

  // Hardware-loop tag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwlp_q <= 1'b0;
    else     hwlp_q <= hwlp_d;
  end

  assign fifo_replace2_o = fwd & hwlp_q;
  assign fifo_is_hwlp_o  = fwd & hwlp_q;
`endif

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      cnt_q        <= '0;
      drop_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      first_q      <= 1'b0;
      first_bit_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      first_q      <= first_d;
      first_bit_q  <= first_bit_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Address queue storage; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (gnt_fire) aq_q[wr_ptr_q] <= fetch_addr_q;
  end

  assign instr_req_o  = (state_q == REQ);
  assign instr_addr_o = fetch_addr_q;
  assign fifo_clear_o = branch_i & ~rst;
  assign fifo_valid_o = fwd;
  assign fifo_addr_o  = fwd ? (first_q ? {pop_addr[31:2], first_bit_q, 1'b0} : pop_addr)
                            : 32'h0;
  assign fifo_rdata_o = fwd ? instr_rdata_i : 32'h0;
  assign busy_o       = (cnt_q != '0) | instr_req_o;

endmodule

// File: tb/tb_riscv_prefetch_req_ctrl.sv
// Directed bench for riscv_prefetch_req_ctrl: inputs change 1 ns after the
// rising edge, outputs are checked on the falling edge.
module tb_riscv_prefetch_req_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_ready_i;
  logic        fifo_clear_o;
  logic        busy_o;
`ifdef RISCV_PREFETCH_HWLP_EN
  logic        hwlp_jump_i;
  logic [31:0] hwlp_target_i;
  logic        fifo_replace2_o;
  logic        fifo_is_hwlp_o;
`endif

  int n_checks;
  int n_errors;

  riscv_prefetch_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en_i     (fetch_en_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_clear_o   (fifo_clear_o),
`ifdef RISCV_PREFETCH_HWLP_EN
    .hwlp_jump_i    (hwlp_jump_i),
    .hwlp_target_i  (hwlp_target_i),
    .fifo_replace2_o(fifo_replace2_o),
    .fifo_is_hwlp_o (fifo_is_hwlp_o),
`endif
    .busy_o         (busy_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, return at the falling edge for checking.
  task automatic cyc(input logic en, input logic rdy, input logic gnt,
                     input logic rv, input logic [31:0] rd,
                     input logic br, input logic [31:0] ba);
    @(posedge clk);
    #1;
    fetch_en_i     = en;
    fifo_ready_i   = rdy;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    branch_i       = br;
    branch_addr_i  = ba;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (instr_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b exp 0", instr_req_o); end
    n_checks++; if (instr_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h exp 0", instr_addr_o); end
    n_checks++; if (fifo_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b exp 0", fifo_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_sequential();
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0) begin n_errors++; $display("FAIL seq_idle_req: got %b exp 0", instr_req_o); end
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_errors++; $display("FAIL seq_req0: got req %b addr %h exp 1 0", instr_req_o, instr_addr_o); end
    cyc(1, 1, 1, 1, 32'h1000_0000, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h4) begin n_errors++; $display("FAIL seq_req4: got %h exp 4", instr_addr_o); end
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h0 || fifo_rdata_o !== 32'h1000_0000) begin n_errors++; $display("FAIL seq_push0: got v %b a %h d %h exp 1 0 10000000", fifo_valid_o, fifo_addr_o, fifo_rdata_o); end
    cyc(1, 1, 1, 1, 32'h1000_0004, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h8) begin n_errors++; $display("FAIL seq_req8: got %h exp 8", instr_addr_o); end
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h4 || fifo_rdata_o !== 32'h1000_0004) begin n_errors++; $display("FAIL seq_push4: got v %b a %h d %h exp 1 4 10000004", fifo_valid_o, fifo_addr_o, fifo_rdata_o); end
    cyc(0, 1, 1, 1, 32'h1000_0008, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'hC || fifo_addr_o !== 32'h8 || fifo_valid_o !== 1'b1) begin n_errors++; $display("FAIL seq_push8: got req_a %h fifo_a %h v %b exp c 8 1", instr_addr_o, fifo_addr_o, fifo_valid_o); end
    cyc(0, 1, 0, 1, 32'h1000_000C, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1 || fifo_addr_o !== 32'hC) begin n_errors++; $display("FAIL seq_tail: got req %b busy %b a %h exp 0 1 c", instr_req_o, busy_o, fifo_addr_o); end
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL seq_done_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_stall();
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc((i == 0) ? 1'b1 : 1'b0, 1, 0, 0, 32'h0, 0, 32'h0);
      n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h10) begin n_errors++; $display("FAIL stall_hold%0d: got req %b addr %h exp 1 10", i, instr_req_o, instr_addr_o); end
    end
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h10) begin n_errors++; $display("FAIL stall_gnt: got req %b addr %h exp 1 10", instr_req_o, instr_addr_o); end
    cyc(0, 1, 0, 1, 32'h2000_0010, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h10 || instr_req_o !== 1'b0) begin n_errors++; $display("FAIL stall_push: got v %b a %h req %b exp 1 10 0", fifo_valid_o, fifo_addr_o, instr_req_o); end
    // A response with nothing outstanding must be ignored.
    cyc(0, 1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL stray_rvalid: got v %b busy %b exp 0 0", fifo_valid_o, busy_o); end
  endtask

  task automatic test_max_outstanding();
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h14) begin n_errors++; $display("FAIL max_req14: got %h exp 14", instr_addr_o); end
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h18) begin n_errors++; $display("FAIL max_req18: got req %b addr %h exp 1 18", instr_req_o, instr_addr_o); end
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL max_limit: got req %b busy %b exp 0 1", instr_req_o, busy_o); end
    cyc(1, 1, 1, 1, 32'h3000_0014, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0 || fifo_addr_o !== 32'h14) begin n_errors++; $display("FAIL max_push14: got req %b a %h exp 0 14", instr_req_o, fifo_addr_o); end
    cyc(0, 1, 1, 1, 32'h3000_0018, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h1C || fifo_addr_o !== 32'h18 || fifo_valid_o !== 1'b1) begin n_errors++; $display("FAIL max_push18: got req_a %h a %h v %b exp 1c 18 1", instr_addr_o, fifo_addr_o, fifo_valid_o); end
    cyc(0, 1, 0, 1, 32'h3000_001C, 0, 32'h0);
    n_checks++; if (fifo_addr_o !== 32'h1C || fifo_rdata_o !== 32'h3000_001C) begin n_errors++; $display("FAIL max_push1c: got a %h d %h exp 1c 3000001c", fifo_addr_o, fifo_rdata_o); end
  endtask

  task automatic test_branch();
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h24) begin n_errors++; $display("FAIL br_req24: got %h exp 24", instr_addr_o); end
    cyc(0, 1, 0, 0, 32'h0, 1, 32'h102);
    n_checks++; if (fifo_clear_o !== 1'b1) begin n_errors++; $display("FAIL br_clear: got %b exp 1", fifo_clear_o); end
    cyc(1, 1, 0, 1, 32'hBAD0_0020, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b0) begin n_errors++; $display("FAIL br_drop20: got v %b clr %b exp 0 0", fifo_valid_o, fifo_clear_o); end
    cyc(0, 1, 1, 1, 32'hBAD0_0024, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b0) begin n_errors++; $display("FAIL br_drop24: got %b exp 0", fifo_valid_o); end
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_errors++; $display("FAIL br_target: got req %b addr %h exp 1 100", instr_req_o, instr_addr_o); end
    cyc(0, 1, 0, 1, 32'h4000_0100, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h102 || fifo_rdata_o !== 32'h4000_0100) begin n_errors++; $display("FAIL br_first: got v %b a %h d %h exp 1 102 40000100", fifo_valid_o, fifo_addr_o, fifo_rdata_o); end
  endtask

  task automatic test_fifo_ready();
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 0, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h104) begin n_errors++; $display("FAIL rdy_req104: got %h exp 104", instr_addr_o); end
    cyc(1, 0, 1, 1, 32'h5000_0104, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h104) begin n_errors++; $display("FAIL rdy_inflight: got req %b v %b a %h exp 0 1 104", instr_req_o, fifo_valid_o, fifo_addr_o); end
    cyc(1, 0, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0) begin n_errors++; $display("FAIL rdy_blocked: got %b exp 0", instr_req_o); end
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b0) begin n_errors++; $display("FAIL rdy_return: got %b exp 0", instr_req_o); end
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108) begin n_errors++; $display("FAIL rdy_resume: got req %b addr %h exp 1 108", instr_req_o, instr_addr_o); end
    cyc(0, 1, 0, 1, 32'h5000_0108, 0, 32'h0);
    n_checks++; if (fifo_addr_o !== 32'h108) begin n_errors++; $display("FAIL rdy_push108: got %h exp 108", fifo_addr_o); end
  endtask

  task automatic test_branch_with_traffic();
    cyc(1, 1, 0, 0, 32'h0, 1, 32'h40);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h40) begin n_errors++; $display("FAIL bt_req40: got %h exp 40", instr_addr_o); end
    cyc(1, 1, 1, 1, 32'hDEAD_0040, 1, 32'h200);
    n_checks++; if (instr_addr_o !== 32'h44 || fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b1) begin n_errors++; $display("FAIL bt_same_cycle: got addr %h v %b clr %b exp 44 0 1", instr_addr_o, fifo_valid_o, fifo_clear_o); end
    cyc(1, 1, 1, 1, 32'hDEAD_0044, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b0) begin n_errors++; $display("FAIL bt_drop44: got %b exp 0", fifo_valid_o); end
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin n_errors++; $display("FAIL bt_target: got req %b addr %h exp 1 200", instr_req_o, instr_addr_o); end
    cyc(0, 1, 0, 1, 32'h6000_0200, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h200) begin n_errors++; $display("FAIL bt_push200: got v %b a %h exp 1 200", fifo_valid_o, fifo_addr_o); end
  endtask

  task automatic test_branch_held();
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0, 1, 32'h300);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h204 || fifo_clear_o !== 1'b1) begin n_errors++; $display("FAIL bh_branch: got req %b addr %h clr %b exp 1 204 1", instr_req_o, instr_addr_o, fifo_clear_o); end
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h204) begin n_errors++; $display("FAIL bh_held: got req %b addr %h exp 1 204", instr_req_o, instr_addr_o); end
    cyc(1, 1, 0, 1, 32'hBAD0_0204, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b0) begin n_errors++; $display("FAIL bh_drop: got %b exp 0", fifo_valid_o); end
    cyc(0, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin n_errors++; $display("FAIL bh_target: got req %b addr %h exp 1 300", instr_req_o, instr_addr_o); end
    cyc(0, 1, 0, 1, 32'h7000_0300, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h300 || fifo_rdata_o !== 32'h7000_0300) begin n_errors++; $display("FAIL bh_push: got v %b a %h d %h exp 1 300 70000300", fifo_valid_o, fifo_addr_o, fifo_rdata_o); end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_top: got %h exp fffffffc", instr_addr_o); end
    cyc(0, 1, 1, 1, 32'h8000_0001, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h0 || fifo_addr_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_zero: got req_a %h fifo_a %h exp 0 fffffffc", instr_addr_o, fifo_addr_o); end
    cyc(0, 1, 0, 1, 32'h8000_0002, 0, 32'h0);
    n_checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h0) begin n_errors++; $display("FAIL wrap_push0: got v %b a %h exp 1 0", fifo_valid_o, fifo_addr_o); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_addr_o !== 32'h8) begin n_errors++; $display("FAIL rm_req8: got %h exp 8", instr_addr_o); end
    @(posedge clk); #1;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hAAAA_5555;
    rst = 1'b1;
    #1;
    n_checks++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || fifo_valid_o !== 1'b0 || busy_o !== 1'b0 || fifo_addr_o !== 32'h0 || fifo_rdata_o !== 32'h0) begin n_errors++; $display("FAIL rm_async: got req %b addr %h v %b busy %b a %h d %h exp all 0", instr_req_o, instr_addr_o, fifo_valid_o, busy_o, fifo_addr_o, fifo_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    fetch_en_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0 || instr_req_o !== 1'b0) begin n_errors++; $display("FAIL rm_release: got busy %b req %b exp 0 0", busy_o, instr_req_o); end
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rm_busy_idle: got %b exp 0", busy_o); end
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL rm_first_req: got req %b addr %h busy %b exp 1 0 1", instr_req_o, instr_addr_o, busy_o); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    fetch_en_i = 1'b0; fifo_ready_i = 1'b1; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    branch_i = 1'b0; branch_addr_i = 32'h0;
`ifdef RISCV_PREFETCH_HWLP_EN
    hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;
`endif
    test_reset();
    test_sequential();
    test_stall();
    test_max_outstanding();
    test_branch();
    test_fifo_ready();
    test_branch_with_traffic();
    test_branch_held();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_prefetch_req_ctrl.md
Name: riscv_prefetch_req_ctrl

Overview:
- Instruction-side memory initiator that writes the fetch FIFO input port.
- Generates sequential word-aligned fetch requests on the instruction memory req/gnt/rvalid interface.
- Tracks up to MAX_OUTSTANDING in-flight transactions and forwards responses with their addresses into the FIFO.
- On branches, clears the FIFO, discards stale responses and restarts fetching at the target.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of granted-but-unanswered requests; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_en_i  in  1  permits new requests
- branch_i  in  1  redirect fetch this cycle
- branch_addr_i  in  32  branch target; bit 0 is ignored, bit 1 is kept
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  request address, always word-aligned
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- fifo_valid_o  out  1  push to FIFO
- fifo_addr_o  out  32  address of the pushed word; the first word after a branch carries the target's bit 1
- fifo_rdata_o  out  32  pushed data, equal to instr_rdata_i
- fifo_ready_i  in  1  FIFO has at least two free entries
- fifo_clear_o  out  1  flush FIFO
- busy_o  out  1  outstanding transactions count or a request is pending

Behaviour:
- Reset values (rst high, asynchronous): all outputs 0; fetch_addr = 0; outstanding count = 0; drop count = 0; state IDLE.
- FSM states:
  - IDLE: instr_req_o = 0.
  - REQ: instr_req_o = 1, waiting for gnt.
- IDLE -> REQ when all hold: fetch_en_i, fifo_ready_i, outstanding count < MAX_OUTSTANDING, and no branch_i this cycle. When branch_i is high, REQ is entered the next cycle.
- REQ, instr_gnt_i high:
  - Push the request address onto the internal address queue, depth MAX_OUTSTANDING.
  - Outstanding count +1; fetch_addr += 4, with 32-bit wrap 0xFFFFFFFC -> 0x00000000.
  - Stay in REQ if the issue conditions still hold, else go to IDLE.
  - Back-to-back grants are allowed, one per cycle.
- REQ, no gnt: instr_req_o and instr_addr_o are held stable. The request is never withdrawn, even if fetch_en_i falls or branch_i rises.
- instr_addr_o = fetch_addr, combinational from the register.
- Response handling on instr_rvalid_i:
  - Pop the address queue; outstanding count -1.
  - If drop count > 0 or branch_i is high: drop count -1 (when >0) and fifo_valid_o = 0.
  - Otherwise fifo_valid_o = 1 in the same cycle: fifo_addr_o = popped address, fifo_rdata_o = instr_rdata_i.
  - Zero-cycle combinational path from rvalid to fifo_valid_o.
- Grant and response in the same cycle: the count is unchanged; push and pop both occur.
- Branch (branch_i high):
  - fifo_clear_o = branch_i, combinational.
  - fetch_addr <= {branch_addr_i[31:2], 2'b00}.
  - first_after_branch flag set, storing branch_addr_i[1].
  - drop count <= outstanding count after this cycle's gnt/rvalid updates. This includes a request granted in the branch cycle and any un-granted request held in REQ, which is counted when granted.
  - The first response forwarded after the branch drop count expires gets fifo_addr_o[1] = stored bit; the flag is then cleared.
- Branch while in REQ without gnt: the held request completes normally, and its response is counted for dropping. The next request uses the target.
- Back-to-back branches: the latest target wins; drop count is recomputed on each one.
- rvalid with zero outstanding is a protocol error: ignored, count saturates at 0.
- busy_o = (outstanding count != 0) | instr_req_o.

Optional Feature:
- Macro RISCV_PREFETCH_HWLP_EN.
- When defined, add ports:
  - hwlp_jump_i  in  1
  - hwlp_target_i  in  32
  - fifo_replace2_o  out  1
  - fifo_is_hwlp_o  out  1
- Hardware-loop jump behaviour:
  - Does not clear the FIFO.
  - Redirects fetch_addr like a branch and drops outstanding responses.
  - Marks the first forwarded response with fifo_replace2_o = 1 and fifo_is_hwlp_o = 1 for that one push.
- When not defined: no such ports, and hardware-loop logic is absent.

Test Plan:
- Reset then fetch_en_i = 1, gnt always 1, rvalid one cycle after gnt:
  - requests at 0x0, 0x4, 0x8.
  - FIFO pushes addr 0x0/0x4/0x8 with matching rdata.
  - outstanding never exceeds 2.
- gnt held low 3 cycles at addr 0x10: instr_req_o and instr_addr_o stay 0x10 for all 4 cycles; only one queue push.
- Two outstanding (0x20, 0x24), then branch_i with target 0x102:
  - fifo_clear_o pulses for that cycle.
  - both stale responses are dropped.
  - next request is at 0x100.
  - first push has fifo_addr_o = 0x102.
- fifo_ready_i = 0: no new instr_req_o; in-flight responses are still pushed; fetching resumes the cycle after ready returns.
- branch_i in the same cycle as rvalid for 0x40 and gnt for 0x44: the 0x40 data is not pushed, and the 0x44 response is dropped.
- rst asserted mid-transaction with 2 outstanding: all outputs 0 immediately; after release, the first request is at 0x0 and busy_o = 0 until it issues.
